boolean_pipe: RTL

Parametrised successor to the two-flop boolean cell, with the same datapath shape: input `a` passes through a register chain (`qx`); `qy` registers a selectable boolean function of `qx` and `b`; `o = a ^ qy`. Over the single-bit cell it adds:
- W independent bit lanes and a configurable `a`-path delay depth;
- a 4-way function select and a clock enable;
- a pipeline-fill valid flag and a saturating counter of cycles with a nonzero output.

It sits in the same datapath slot as the single-bit cell. With W=1, DEPTH=1, mode=00 it is cycle-equivalent to that cell.

---
 rtl/boolean_pipe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/boolean_pipe.sv
// W-lane boolean cell: delayed `a` chain, registered selectable function of
// the chain tail and `b`, combinational output, fill flag and hit counter.
module boolean_pipe #(
    parameter int W     = 8,
    parameter int DEPTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [W-1:0]     qx,
    output logic [W-1:0]     qy,
    output logic [W-1:0]     o,
    output logic             valid_out,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int                FILL_W   = $clog2(DEPTH + 2);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    // Mode 00 keeps the legacy NOR so W=1/DEPTH=1 matches the original cell.
    function automatic logic [W-1:0] bool_fn(
        input logic [1:0]   sel,
        input logic [W-1:0] x,
        input logic [W-1:0] y
    );
        logic [W-1:0] r;
        case (sel)
            2'b00:   r = ~(x | y);
            2'b01:   r = ~(x & y);
            2'b10:   r = x ^ y;
            2'b11:   r = ~(x ^ y);
            default: r = ~(x | y);
        endcase
        return r;
    endfunction

    logic [W-1:0]      x_q [DEPTH];
    logic [W-1:0]      x_d [DEPTH];
    logic [W-1:0]      qy_q;
    logic [W-1:0]      qy_d;
    logic [W-1:0]      c_s;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic              valid_q;
    logic              valid_d;
    logic [CNT_W-1:0]  hit_q;
    logic [CNT_W-1:0]  hit_d;
    logic              hit_s;

    assign c_s       = bool_fn(mode, x_q[DEPTH-1], b);
    assign o         = a ^ qy_q;
    assign hit_s     = en & valid_q & (|o);
    assign qx        = x_q[DEPTH-1];
    assign qy        = qy_q;
    assign valid_out = valid_q;
    assign hit_cnt   = hit_q;

    // Next state of the `a` delay chain.
    always_comb begin
        x_d = x_q;
        if (en) begin
            x_d[0] = a;
            for (int k = 1; k < DEPTH; k++) begin
                x_d[k] = x_q[k-1];
            end
        end else begin
            x_d = x_q;
        end
    end

    // Next state of the function register.
    always_comb begin
        qy_d = qy_q;
        if (en) begin
            qy_d = c_s;
        end else begin
            qy_d = qy_q;
        end
    end

    // Fill counter saturates at DEPTH+1, so valid never drops until reset.
    always_comb begin
        fill_d = fill_q;
        if (en && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
        end else begin
            fill_d = fill_q;
        end
        valid_d = (fill_d == FILL_MAX);
    end

    // Hit counter: clear wins over increment and is not gated by en.
    always_comb begin
        hit_d = hit_q;
        if (clr) begin
            hit_d = {CNT_W{1'b0}};
        end else if (hit_s && (hit_q != CNT_MAX)) begin
            hit_d = hit_q + CNT_W'(1);
        end else begin
            hit_d = hit_q;
        end
    end

    // Delay chain registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                x_q[k] <= {W{1'b0}};
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                x_q[k] <= x_d[k];
            end
        end
    end

    // Function, fill and hit registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qy_q    <= {W{1'b0}};
            fill_q  <= {FILL_W{1'b0}};
            valid_q <= 1'b0;
            hit_q   <= {CNT_W{1'b0}};
        end else begin
            qy_q    <= qy_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
        end
    end

endmodule
